// File: rtl/mii_rx_checker_if.sv
// MII receive word input and frame beat output bundle for mii_rx_checker.
interface mii_rx_checker_if;
    logic [63:0] i_mii_rx_d;
    logic [7:0]  i_mii_rx_c;
    logic [63:0] o_rx_d;
    logic [7:0]  o_rx_keep;
    logic        o_rx_valid;
    logic        o_rx_last;

    // Checker side: consumes MII words, produces frame beats
    modport slave (
        input  i_mii_rx_d, i_mii_rx_c,
        output o_rx_d, o_rx_keep, o_rx_valid, o_rx_last
    );

    // Source/sink side: drives MII words, observes frame beats
    modport master (
        output i_mii_rx_d, i_mii_rx_c,
        input  o_rx_d, o_rx_keep, o_rx_valid, o_rx_last
    );
endinterface

// File: rtl/mii_rx_checker.sv
// 64-bit MII receive checker: finds START/TERMINATE, strips control bytes,
// emits keep-qualified beats, measures frame length and flags framing errors.
// Optional inter-packet-gap check enabled by defining MII_RX_IPG_CHECK_EN.
module mii_rx_checker #(
    parameter int unsigned PAYLOAD_MAX_SIZE = 1500,
    parameter int unsigned MIN_FRAME_BYTES  = 71,
    parameter int unsigned MAX_FRAME_BYTES  = PAYLOAD_MAX_SIZE + 25,
    parameter int unsigned MIN_IPG_BYTES    = 12
) (
    input  logic                  clk,
    input  logic                  i_rst,
    mii_rx_checker_if.slave       mii,
    output logic                  o_frame_done,
    output logic [15:0]           o_frame_len,
    output logic [4:0]            o_err_flags,
    output logic [31:0]           o_good_cnt,
    output logic [31:0]           o_bad_cnt
);
    localparam logic [7:0] START_CH = 8'hFB;
    localparam logic [7:0] TERM_CH  = 8'hFD;
    localparam logic [7:0] IDLE_CH  = 8'h07;
    localparam logic [7:0] IPG_MIN  = 8'(MIN_IPG_BYTES);

    typedef enum logic [1:0] {S_IDLE, S_DATA, S_DROP} state_t;

    state_t      state_q, state_d;
    logic [15:0] len_q, len_d;
    logic        ipg_flag_q, ipg_flag_d;
    logic [7:0]  ipg_cnt_q;
    logic        ipg_armed_q;
    logic        ipg_short_c;

    logic [2:0]  k_c;
    logic        start_ok_c, start_err_c, term_ok_c, fd_ctrl_c, all_idle_c;
    logic [4:0]  add_c;
    logic [16:0] sum_c;
    logic [15:0] len_sat_c;
    logic        long_c, short_c;

    logic        beat_c, last_c, close_c, start_pulse_c;
    logic [7:0]  keep_c;
    logic [4:0]  close_flags_c;

    // Decode the incoming word: first control lane, terminate/start/idle patterns
    always_comb begin
        k_c = 3'd0;
        for (int i = 7; i >= 0; i--) begin
            if (mii.i_mii_rx_c[i]) k_c = 3'(i);
        end
        start_ok_c  = (mii.i_mii_rx_c == 8'h01) && (mii.i_mii_rx_d[7:0] == START_CH);
        term_ok_c   = (mii.i_mii_rx_c == (8'hFF << k_c)) &&
                      (mii.i_mii_rx_d[{k_c, 3'b000} +: 8] == TERM_CH);
        fd_ctrl_c   = 1'b0;
        start_err_c = 1'b0;
        all_idle_c  = 1'b1;
        for (int i = 0; i < 8; i++) begin
            if (mii.i_mii_rx_c[i] && (mii.i_mii_rx_d[8*i +: 8] == TERM_CH)) fd_ctrl_c = 1'b1;
            if ((i > 0) && mii.i_mii_rx_c[i] && (mii.i_mii_rx_d[8*i +: 8] == START_CH))
                start_err_c = 1'b1;
            if (!(mii.i_mii_rx_c[i] && (mii.i_mii_rx_d[8*i +: 8] == IDLE_CH))) all_idle_c = 1'b0;
            if ((i > int'(k_c)) && (mii.i_mii_rx_d[8*i +: 8] != IDLE_CH)) term_ok_c = 1'b0;
        end
    end

    // Running length for this word, saturating, with size limits
    always_comb begin
        add_c     = (mii.i_mii_rx_c == 8'h00) ? 5'd8 : 5'(k_c);
        sum_c     = 17'(len_q) + 17'(add_c);
        len_sat_c = sum_c[16] ? 16'hFFFF : sum_c[15:0];
        long_c    = sum_c > 17'(MAX_FRAME_BYTES);
        short_c   = sum_c < 17'(MIN_FRAME_BYTES);
    end

    assign ipg_short_c = ipg_armed_q && (ipg_cnt_q < IPG_MIN);

    // State register
    always_ff @(posedge clk or posedge i_rst) begin
        if (i_rst) state_q <= S_IDLE;
        else       state_q <= state_d;
    end

    // Next state and next output values
    always_comb begin
        state_d       = state_q;
        beat_c        = 1'b0;
        last_c        = 1'b0;
        keep_c        = 8'h00;
        close_c       = 1'b0;
        close_flags_c = 5'b00000;
        start_pulse_c = 1'b0;
        len_d         = len_q;
        ipg_flag_d    = ipg_flag_q;
        case (state_q)
            S_IDLE: begin
                if (start_ok_c) begin
                    state_d    = S_DATA;
                    beat_c     = 1'b1;
                    keep_c     = 8'hFE;
                    len_d      = 16'd7;
                    ipg_flag_d = ipg_short_c;
                end else if (start_err_c) begin
                    start_pulse_c = 1'b1;
                end
            end
            S_DATA: begin
                beat_c = 1'b1;
                len_d  = len_sat_c;
                if (mii.i_mii_rx_c == 8'h00) begin
                    keep_c = 8'hFF;
                    if (long_c) begin
                        last_c        = 1'b1;
                        close_c       = 1'b1;
                        close_flags_c = {ipg_flag_q, 1'b1, 1'b0, 1'b0, 1'b0};
                        state_d       = S_DROP;
                    end
                end else begin
                    keep_c  = 8'((8'h01 << k_c) - 8'h01);
                    last_c  = 1'b1;
                    close_c = 1'b1;
                    if (term_ok_c) begin
                        close_flags_c = {ipg_flag_q, long_c, !long_c && short_c, 1'b0, 1'b0};
                        state_d       = S_IDLE;
                    end else begin
                        close_flags_c = {ipg_flag_q, long_c, 1'b0, 1'b1, 1'b0};
                        state_d       = S_DROP;
                    end
                end
            end
            S_DROP: begin
                if (fd_ctrl_c || all_idle_c) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Output, length and statistics registers
    always_ff @(posedge clk or posedge i_rst) begin
        if (i_rst) begin
            mii.o_rx_d     <= '0;
            mii.o_rx_keep  <= '0;
            mii.o_rx_valid <= 1'b0;
            mii.o_rx_last  <= 1'b0;
            o_frame_done   <= 1'b0;
            o_frame_len    <= '0;
            o_err_flags    <= '0;
            o_good_cnt     <= '0;
            o_bad_cnt      <= '0;
            len_q          <= '0;
            ipg_flag_q     <= 1'b0;
        end else begin
            mii.o_rx_d     <= beat_c ? mii.i_mii_rx_d : 64'd0;
            mii.o_rx_keep  <= keep_c;
            mii.o_rx_valid <= beat_c;
            mii.o_rx_last  <= last_c;
            o_frame_done   <= close_c;
            o_err_flags    <= close_c ? close_flags_c : (start_pulse_c ? 5'b00001 : 5'b00000);
            len_q          <= len_d;
            ipg_flag_q     <= ipg_flag_d;
            if (close_c) begin
                o_frame_len <= len_sat_c;
                if (close_flags_c == 5'b00000) o_good_cnt <= o_good_cnt + 32'd1;
                else                           o_bad_cnt  <= o_bad_cnt + 32'd1;
            end
        end
    end

`ifdef MII_RX_IPG_CHECK_EN
    logic [3:0] idle_bytes_c;
    logic [8:0] ipg_sum_c;

    // Count idle control bytes in the current word
    always_comb begin
        idle_bytes_c = 4'd0;
        for (int i = 0; i < 8; i++) begin
            if (mii.i_mii_rx_c[i] && (mii.i_mii_rx_d[8*i +: 8] == IDLE_CH))
                idle_bytes_c = idle_bytes_c + 4'd1;
        end
        ipg_sum_c = 9'(ipg_cnt_q) + 9'(idle_bytes_c);
    end

    // Gap counter: restarts at frame end, accumulates idles until the next start
    always_ff @(posedge clk or posedge i_rst) begin
        if (i_rst) begin
            ipg_cnt_q   <= '0;
            ipg_armed_q <= 1'b0;
        end else if (close_c) begin
            ipg_cnt_q   <= term_ok_c ? 8'(idle_bytes_c) : 8'd0;
            ipg_armed_q <= 1'b1;
        end else if (state_q != S_DATA) begin
            ipg_cnt_q   <= ipg_sum_c[8] ? 8'hFF : ipg_sum_c[7:0];
        end
    end
`else
    assign ipg_cnt_q   = 8'd0;
    assign ipg_armed_q = 1'b0;
`endif

endmodule
